operand_memory_writer: RTL and testbench

Writable 16-entry × 16-bit operand store with a burst-load engine. It is the write-side counterpart to the team's read-only operand lookup.
- A valid/ready stream fills consecutive addresses, starting at a chosen base and wrapping modulo DEPTH.
- A single-word direct write port patches individual entries while idle.
- A registered read port serves the ALU datapath.

---
 rtl/operand_mem_pkg.sv | 18 +
 rtl/operand_mem_array.sv | 38 +++
 rtl/operand_memory_writer.sv | 113 +++++++++++
 tb/tb_operand_memory_writer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/operand_mem_pkg.sv
// Shared constants and FSM encoding for the operand store
// and its burst-load engine.
package operand_mem_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int DEPTH_DEF  = 16;
  localparam int ADDR_W_DEF = 4;
  localparam int CNT_W      = ADDR_W_DEF + 1;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH_DEF);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DONE
  } state_e;

endpackage

// File: rtl/operand_mem_array.sv
// Operand storage: async-reset clear, one write port,
// registered read port (read-before-write on collision).
module operand_mem_array
  import operand_mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rdata_q <= '0;
    end else begin
      if (we) begin
        mem_q[waddr] <= wdata;
      end
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/operand_memory_writer.sv
// Writable operand store with a valid/ready burst-load engine
// and an idle-only direct write port.
module operand_memory_writer
  import operand_mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_base,
  input  logic [ADDR_W:0]   load_count,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_rej,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   remain_q, remain_d;
  logic              wr_rej_q;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      remain_q <= '0;
      wr_rej_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      remain_q <= remain_d;
      wr_rej_q <= wr_en & busy;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    remain_d  = remain_q;
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    in_ready  = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        mem_we = wr_en;
        if (load_start) begin
          if (load_count == '0) begin
            state_d = ST_DONE;
          end else begin
            ptr_d    = load_base;
            remain_d = (load_count > CNT_MAX) ? CNT_MAX
                                              : load_count;
            state_d  = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        in_ready = 1'b1;
        // Stream owns the write port; direct writes are dropped here
        if (in_valid) begin
          mem_we    = 1'b1;
          mem_waddr = ptr_q;
          mem_wdata = in_data;
          ptr_d     = ptr_q + 1'b1;
          remain_d  = remain_q - 1'b1;
          if (remain_q == 1) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy   = (state_q != ST_IDLE);
  assign wr_rej = wr_rej_q;

  operand_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_operand_memory_writer.sv
// Randomized bench for operand_memory_writer against an
// array-based reference of the store contents.
module tb_operand_memory_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_start;
  logic [3:0]  load_base;
  logic [4:0]  load_count;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        wr_rej;
  logic [3:0]  rd_addr;
  logic [15:0] rd_data;
  logic        busy;
  logic        done;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [15:0] model [16];

  operand_memory_writer dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .load_base  (load_base),
    .load_count (load_count),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_rej     (wr_rej),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic read_all(input string tag);
    for (int a = 0; a < 16; a++) begin
      rd_addr = a[3:0];
      tick();
      check(tag, rd_data, model[a]);
    end
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_rdy"},  in_ready, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_rej"},  wr_rej, 0);
    check({tag, "_rd"},   rd_data, 0);
  endtask

  // Starts at a negedge in IDLE; returns at a negedge in IDLE.
  task automatic burst(input logic [3:0] base,
                       input logic [4:0] cnt,
                       input bit         stall,
                       input int         rej_at,
                       input int         abort_after);
    int k;
    int got;
    int idx;
    int run;
    bit rej_exp;
    bit injected;
    k        = (cnt > 16) ? 16 : int'(cnt);
    got      = 0;
    run      = 0;
    rej_exp  = 0;
    injected = 0;
    load_base  = base;
    load_count = cnt;
    load_start = 1'b1;
    in_valid   = 1'b0;
    tick();
    load_start = 1'b0;
    while (got < k) begin
      check("ld_rdy",  in_ready, 1);
      check("ld_done", done, 0);
      check("ld_busy", busy, 1);
      check("ld_rej",  wr_rej, rej_exp);
      wr_en   = 1'b0;
      rej_exp = 0;
      if (abort_after >= 0 && got == abort_after) begin
        rst      = 1'b1;
        in_valid = 1'b0;
        #1;
        check_reset_outs("mid_rst");
        for (int a = 0; a < 16; a++) model[a] = '0;
        tick();
        rst = 1'b0;
        return;
      end
      if (got == rej_at && !injected) begin
        wr_en    = 1'b1;
        wr_addr  = 4'd9;
        wr_data  = 16'h1234;
        rej_exp  = 1;
        injected = 1;
      end
      in_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (run >= 3) in_valid = 1'b1;
      run = in_valid ? 0 : run + 1;
      in_data = 16'($urandom);
      if (in_valid) begin
        idx = (int'(base) + got) % 16;
        model[idx] = in_data;
        got++;
      end
      tick();
    end
    check("dn_done", done, 1);
    check("dn_rdy",  in_ready, 0);
    check("dn_busy", busy, 1);
    check("dn_rej",  wr_rej, rej_exp);
    wr_en    = 1'b0;
    // extra word offered during DONE must not be taken
    in_valid = 1'b1;
    in_data  = 16'($urandom);
    tick();
    check("post_done", done, 0);
    check("post_busy", busy, 0);
    check("post_rdy",  in_ready, 0);
    in_valid = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    load_start = 1'b0;
    load_base  = '0;
    load_count = '0;
    in_valid   = 1'b0;
    in_data    = '0;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    rd_addr    = '0;
    for (int a = 0; a < 16; a++) model[a] = '0;
    tick();
    tick();
    check_reset_outs("reset");
    rst = 1'b0;
    read_all("reset_clr");

    burst(4'd3, 5'd4, 0, -1, -1);
    read_all("basic");
    burst(4'd14, 5'd4, 1, -1, -1);
    read_all("wrap");
    burst(4'd5, 5'd16, 0, -1, -1);
    read_all("full");
    burst(4'd7, 5'd0, 0, -1, -1);
    check("zero_busy_idle", busy, 0);
    read_all("zero");
    burst(4'd2, 5'd31, 1, -1, -1);
    read_all("clamp");
    burst(4'd10, 5'd6, 0, 1, -1);
    read_all("rej");

    // Idle direct write with same-cycle read of that entry
    wr_en   = 1'b1;
    wr_addr = 4'd9;
    wr_data = 16'h1234;
    rd_addr = 4'd9;
    tick();
    wr_en = 1'b0;
    check("wr_old", rd_data, model[9]);
    check("wr_norej", wr_rej, 0);
    model[9] = 16'h1234;
    tick();
    check("wr_new", rd_data, 16'h1234);

    burst(4'd4, 5'd8, 0, -1, 2);
    read_all("rst_mid");
    burst(4'd4, 5'd8, 1, -1, -1);
    read_all("after_rst");

    for (int t = 0; t < 6; t++) begin
      for (int w = 0; w < 3; w++) begin
        wr_en   = 1'b1;
        wr_addr = 4'($urandom);
        wr_data = 16'($urandom);
        model[wr_addr] = wr_data;
        tick();
      end
      wr_en = 1'b0;
      burst(4'($urandom), 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)),
            int'($urandom_range(0, 3)), -1);
      read_all("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
